// File: rtl/bcd_to_fnd_pkg.sv
// Shared constants and decode helpers for the add/subtract FND display block.
// Segment order is {dp,g,f,e,d,c,b,a}, active-low; digit enables are active-low.
package bcd_to_fnd_pkg;

  localparam logic [7:0] FONT_0 = 8'hC0;
  localparam logic [7:0] FONT_1 = 8'hF9;
  localparam logic [7:0] FONT_2 = 8'hA4;
  localparam logic [7:0] FONT_3 = 8'hB0;
  localparam logic [7:0] FONT_4 = 8'h99;
  localparam logic [7:0] FONT_5 = 8'h92;
  localparam logic [7:0] FONT_6 = 8'h82;
  localparam logic [7:0] FONT_7 = 8'hF8;
  localparam logic [7:0] FONT_8 = 8'h80;
  localparam logic [7:0] FONT_9 = 8'h90;
  localparam logic [7:0] FONT_A = 8'h88;
  localparam logic [7:0] FONT_B = 8'h83;
  localparam logic [7:0] FONT_C = 8'hC6;
  localparam logic [7:0] FONT_D = 8'hA1;
  localparam logic [7:0] FONT_E = 8'h86;
  localparam logic [7:0] FONT_F = 8'h8E;
  localparam logic [7:0] FONT_BLANK = 8'hFF;

  localparam logic [3:0] DIGIT_0   = 4'b1110;
  localparam logic [3:0] DIGIT_1   = 4'b1101;
  localparam logic [3:0] DIGIT_2   = 4'b1011;
  localparam logic [3:0] DIGIT_3   = 4'b0111;
  localparam logic [3:0] DIGIT_OFF = 4'b1111;

  function automatic logic [7:0] font_of(input logic [3:0] val);
    logic [7:0] f;
    case (val)
      4'h0: f = FONT_0;
      4'h1: f = FONT_1;
      4'h2: f = FONT_2;
      4'h3: f = FONT_3;
      4'h4: f = FONT_4;
      4'h5: f = FONT_5;
      4'h6: f = FONT_6;
      4'h7: f = FONT_7;
      4'h8: f = FONT_8;
      4'h9: f = FONT_9;
      4'hA: f = FONT_A;
      4'hB: f = FONT_B;
      4'hC: f = FONT_C;
      4'hD: f = FONT_D;
      4'hE: f = FONT_E;
      default: f = FONT_F;
    endcase
    return f;
  endfunction

  function automatic logic [3:0] digit_of(input logic [1:0] sel);
    logic [3:0] d;
    case (sel)
      2'd0: d = DIGIT_0;
      2'd1: d = DIGIT_1;
      2'd2: d = DIGIT_2;
      default: d = DIGIT_3;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/bcd_to_fnd_add_sub_4bit.sv
// Combinational 4-bit ripple add/subtract: B is inverted and carry-in set when
// i_mode=1, so o_c=1 on subtract means no borrow.
module add_sub_4bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_mode,
  output logic [3:0] o_sum,
  output logic       o_c
);

  logic [3:0] b_x;
  logic [4:0] carry;

  assign b_x      = i_b ^ {4{i_mode}};
  assign carry[0] = i_mode;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign o_sum[i]   = i_a[i] ^ b_x[i] ^ carry[i];
    assign carry[i+1] = (i_a[i] & b_x[i]) | (carry[i] & (i_a[i] ^ b_x[i]));
  end

  assign o_c = carry[4];

endmodule

// File: rtl/bcd_to_fnd.sv
// Registered add/subtract with hex glyph output onto one scanned FND digit.
// Blanking forces digit and font off but the carry register still tracks the adder.
module bcd_to_fnd
  import bcd_to_fnd_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_mode,
  input  logic [1:0] i_digitSelect,
  input  logic       i_en,
  output logic [3:0] o_digit,
  output logic [7:0] o_font,
  output logic       o_c
);

  logic [3:0] sum;
  logic       carry;

  logic [3:0] digit_d, digit_q;
  logic [7:0] font_d,  font_q;
  logic       c_d,     c_q;

  add_sub_4bit u_add_sub (
    .i_a    (i_a),
    .i_b    (i_b),
    .i_mode (i_mode),
    .o_sum  (sum),
    .o_c    (carry)
  );

  always_comb begin
    digit_d = DIGIT_OFF;
    font_d  = FONT_BLANK;
    c_d     = carry;
    if (!i_en) begin
      digit_d = digit_of(i_digitSelect);
      font_d  = font_of(sum);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      digit_q <= DIGIT_OFF;
      font_q  <= FONT_BLANK;
      c_q     <= 1'b0;
    end else begin
      digit_q <= digit_d;
      font_q  <= font_d;
      c_q     <= c_d;
    end
  end

  assign o_digit = digit_q;
  assign o_font  = font_q;
  assign o_c     = c_q;

endmodule

// File: tb/tb_bcd_to_fnd.sv
// Self-checking bench: expected outputs are queued when inputs are driven and
// compared one cycle later when the registered outputs appear.
module tb_bcd_to_fnd;

  typedef struct packed {
    logic [3:0] digit;
    logic [7:0] font;
    logic       c;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] a, b;
  logic       mode;
  logic [1:0] sel;
  logic       en;
  logic [3:0] digit;
  logic [7:0] font;
  logic       c;

  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t sb[$];

  bcd_to_fnd dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_a           (a),
    .i_b           (b),
    .i_mode        (mode),
    .i_digitSelect (sel),
    .i_en          (en),
    .o_digit       (digit),
    .o_font        (font),
    .o_c           (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_font(input logic [3:0] v);
    logic [7:0] tbl [16];
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return tbl[v];
  endfunction

  function automatic exp_t model(input logic [3:0] ma, input logic [3:0] mb,
                                 input logic mm, input logic [1:0] ms, input logic me);
    exp_t e;
    int   r;
    if (mm) begin
      r   = int'(ma) - int'(mb);
      e.c = (ma >= mb);
    end else begin
      r   = int'(ma) + int'(mb);
      e.c = (r > 15);
    end
    if (me) begin
      e.digit = 4'b1111;
      e.font  = 8'hFF;
    end else begin
      e.digit = 4'b1111 & ~(4'b0001 << ms);
      e.font  = ref_font(4'(r & 15));
    end
    return e;
  endfunction

  // Drive on the falling edge, then compare after the capturing rising edge.
  task automatic apply(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                       input logic tm, input logic [1:0] ts, input logic te);
    exp_t e;
    @(negedge clk);
    a = ta; b = tb; mode = tm; sel = ts; en = te;
    sb.push_back(model(ta, tb, tm, ts, te));
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_digit"}, 32'(digit), 32'(e.digit));
      check({tag, "_font"},  32'(font),  32'(e.font));
      check({tag, "_c"},     32'(c),     32'(e.c));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a = 4'h5; b = 4'hE; mode = 1'b0; sel = 2'd2; en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_digit", 32'(digit), 32'hF);
    check("rst_font",  32'(font),  32'hFF);
    check("rst_c",     32'(c),     32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(model(4'h5, 4'hE, 1'b0, 2'd2, 1'b0));
    @(posedge clk);
    #1;
    begin
      exp_t e;
      e = sb.pop_front();
      check("rel_digit", 32'(digit), 32'(e.digit));
      check("rel_font",  32'(font),  32'(e.font));
      check("rel_c",     32'(c),     32'(e.c));
    end

    for (int s = 0; s < 4; s++)
      apply("scan", 4'h3, 4'h4, 1'b0, 2'(s), 1'b0);

    for (int i = 0; i < 16; i++)
      apply("addF", 4'(i), 4'(15 - i), 1'b0, 2'(i % 4), 1'b0);
    apply("add88", 4'h8, 4'h8, 1'b0, 2'd0, 1'b0);
    apply("wrapF1", 4'hF, 4'h1, 1'b0, 2'd1, 1'b0);

    apply("sub82", 4'h8, 4'h2, 1'b1, 2'd0, 1'b0);
    apply("sub91", 4'h9, 4'h1, 1'b1, 2'd1, 1'b0);
    apply("sub25", 4'h2, 4'h5, 1'b1, 2'd2, 1'b0);
    apply("sub01", 4'h0, 4'h1, 1'b1, 2'd3, 1'b0);
    apply("subeq", 4'h7, 4'h7, 1'b1, 2'd0, 1'b0);

    apply("blank55", 4'h5, 4'h5, 1'b0, 2'd3, 1'b1);
    apply("blankC",  4'hC, 4'h9, 1'b0, 2'd0, 1'b1);
    apply("unblank", 4'hC, 4'h9, 1'b0, 2'd2, 1'b0);

    for (int k = 0; k < 20; k++)
      apply("rand", 4'($urandom_range(15)), 4'($urandom_range(15)),
            1'($urandom_range(1)), 2'($urandom_range(3)), 1'($urandom_range(3) == 0));

    // Mid-cycle async reset while a glyph is displayed.
    apply("pre_rst", 4'h6, 4'h6, 1'b0, 2'd1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_digit", 32'(digit), 32'hF);
    check("arst_font",  32'(font),  32'hFF);
    check("arst_c",     32'(c),     32'h0);
    @(posedge clk);
    #1;
    check("arst_hold_font", 32'(font), 32'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    apply("post_rst", 4'hA, 4'h3, 1'b1, 2'd3, 1'b0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_to_fnd.md
# bcd_to_fnd

Registered 4-bit add/subtract-and-display block for a 4-digit, common-anode, seven-segment (FND) module. It adds or subtracts two 4-bit operands and renders the 4-bit result as one hexadecimal glyph. The glyph is driven onto the digit chosen by an external scan select. It sits between the operand/mode switches and the board FND pins, downstream of the digit-scan counter.

## Interface
- No parameters.
- i_clk  input  1  system clock; all state updates on rising edge.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_a  input  4  operand A, unsigned.
- i_b  input  4  operand B, unsigned.
- i_mode  input  1  0 = A+B, 1 = A−B.
- i_digitSelect  input  2  digit to drive, 0..3.
- i_en  input  1  blank control; 1 = all digits off, 0 = display active.
- o_digit  output  4  digit enables, active-low, one-hot-low.
- o_font  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.
- o_c  output  1  carry out of the adder.

## Operation
- Arithmetic:
  - sum[3:0] = A + (B XOR {4{mode}}) + mode, modulo 16.
  - o_c = bit 4 of the 5-bit result.
  - Subtract: o_c=1 means no borrow (A≥B); o_c=0 means borrow.
- Digit decode when i_en=0:
  - select 0 → 4'b1110
  - select 1 → 4'b1101
  - select 2 → 4'b1011
  - select 3 → 4'b0111
- Font decode when i_en=0 (dp always off, bit 7 = 1):
  - 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8
  - 8→80, 9→90, A→88, B→83, C→C6, D→A1, E→86, F→8E
- i_en=1 forces o_digit=4'b1111 and o_font=8'hFF, regardless of other inputs.
- o_c is computed regardless of i_en.
- Every digit position shows the same sum glyph. The scan source multiplexes by cycling i_digitSelect.

## Timing
- Adder and decoders are combinational. o_digit, o_font and o_c are registered.
- Latency: exactly 1 cycle from any input change to the output, captured at the next rising i_clk.
- Reset values: o_digit=4'b1111, o_font=8'hFF, o_c=0.
- Reset is asserted asynchronously. Outputs go to reset values immediately, including mid-operation.
- Release is synchronous to the next rising edge. The first edge after release loads the current decode.
- Simultaneous changes of operands, mode, select and enable are all sampled on the same edge. No ordering dependencies.
- Wrap-around:
  - F+1 → sum 0, o_c=1.
  - 0−1 → sum F, o_c=0.
- Inputs are assumed synchronous to i_clk. No internal synchronizers.

## Structure
- Package bcd_to_fnd_pkg holds:
  - the 16 font constants (FONT_0..FONT_F)
  - the digit-pattern constants (DIGIT_0..DIGIT_3, DIGIT_OFF=4'b1111)
  - FONT_BLANK=8'hFF
- Sub-module add_sub_4bit: combinational 4-bit ripple adder of four full-adder stages, with XOR-on-B and carry-in = mode.
  - Ports: i_a, i_b, i_mode, o_sum[3:0], o_c.
- Top contains the digit decoder, the font decoder, blank muxing, and the output register.

## Test plan
- Reset: hold i_reset_n=0 with arbitrary inputs → o_digit=1111, o_font=FF, o_c=0. Deassert: values update on the first rising edge.
- Digit scan: mode=0, A=3, B=4, en=0, select 0..3 → o_digit 1110/1101/1011/0111, o_font=F8 (glyph 7) each cycle, one cycle late.
- Add sweep: A=0..F, B=F−A, mode=0 → sum F, o_font=8E, o_c=0. Also A=8, B=8 → sum 0, C0, o_c=1.
- Subtract: mode=1 cases:
  - A=8, B=2 → 6, 82, o_c=1
  - A=9, B=1 → 8, 80, o_c=1
  - A=2, B=5 → D, A1, o_c=0
- Blank: en=1 with A=5, B=5 → o_digit=1111, o_font=FF. o_c=0 and still tracks the adder.
- Async reset mid-operation: drop i_reset_n between edges while displaying → outputs go to reset values without waiting for a clock edge.
